// File: rtl/hu_audio_dma_pkg.sv
// Shared types and constants for the audio encoder DMA read/unpack stage.
package hu_audio_dma_pkg;
  localparam int DMA_W   = 64;
  localparam int SMP_W   = 32;
  localparam int BURST_W = 16;

  localparam logic [2:0] DMA_SIZE_64 = 3'b011;

  typedef enum logic [2:0] {IDLE, REQ, DATA, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [2:0]  size;
    logic [31:0] length;
    logic [31:0] index;
  } dma_ctrl_msg_t;
endpackage

// File: rtl/hu_audio_dma_rd_unpack_if.sv
// ESP DMA read channels plus the outgoing sample stream.
interface hu_audio_dma_rd_unpack_if;
  import hu_audio_dma_pkg::*;

  logic              dma_read_ctrl_valid;
  logic              dma_read_ctrl_ready;
  logic [31:0]       dma_read_ctrl_data_index;
  logic [31:0]       dma_read_ctrl_data_length;
  logic [2:0]        dma_read_ctrl_data_size;
  logic              dma_read_chnl_valid;
  logic              dma_read_chnl_ready;
  logic [DMA_W-1:0]  dma_read_chnl_data;
  logic              smp_valid;
  logic              smp_ready;
  logic [SMP_W-1:0]  smp_data;
  logic              smp_last;

  modport master (
    output dma_read_ctrl_valid, dma_read_ctrl_data_index, dma_read_ctrl_data_length,
           dma_read_ctrl_data_size, dma_read_chnl_ready, smp_valid, smp_data, smp_last,
    input  dma_read_ctrl_ready, dma_read_chnl_valid, dma_read_chnl_data, smp_ready
  );

  modport slave (
    input  dma_read_ctrl_valid, dma_read_ctrl_data_index, dma_read_ctrl_data_length,
           dma_read_ctrl_data_size, dma_read_chnl_ready, smp_valid, smp_data, smp_last,
    output dma_read_ctrl_ready, dma_read_chnl_valid, dma_read_chnl_data, smp_ready
  );
endinterface

// File: rtl/hu_audio_beat_unpack.sv
// Holds one DMA beat and emits it as two samples, low half first.
module hu_audio_beat_unpack #(
  parameter int DMA_W = 64,
  parameter int SMP_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             drop_hi,
  input  logic             beat_valid,
  input  logic [DMA_W-1:0] beat_data,
  output logic             beat_ready,
  output logic             smp_valid,
  output logic [SMP_W-1:0] smp_data,
  input  logic             smp_ready
);
  logic [DMA_W-1:0] beat_q;
  logic             lo_pend, hi_pend;
  logic             beat_hs, smp_hs;

  assign smp_valid = lo_pend | hi_pend;
  assign smp_data  = lo_pend ? beat_q[SMP_W-1:0] : beat_q[DMA_W-1:SMP_W];
  assign smp_hs    = smp_valid & smp_ready;
  // A new beat may replace a lone high half in the cycle it is consumed.
  assign beat_ready = en & ~lo_pend & (~hi_pend | smp_ready);
  assign beat_hs    = beat_valid & beat_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_q  <= '0;
      lo_pend <= 1'b0;
      hi_pend <= 1'b0;
    end else if (beat_hs) begin
      beat_q  <= beat_data;
      lo_pend <= 1'b1;
      hi_pend <= ~drop_hi;
    end else if (smp_hs) begin
      if (lo_pend) lo_pend <= 1'b0;
      else         hi_pend <= 1'b0;
    end
  end
endmodule

// File: rtl/hu_audio_dma_rd_unpack.sv
// DMA burst-read sequencer feeding the beat unpacker; owns the FSM and counters.
module hu_audio_dma_rd_unpack import hu_audio_dma_pkg::*; #(
  parameter int DMA_W   = 64,
  parameter int SMP_W   = 32,
  parameter int BURST_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [31:0]        cfg_base_index,
  input  logic [31:0]        cfg_num_samples,
  input  logic [BURST_W-1:0] cfg_burst_beats,
  output logic               busy,
  output logic               done,
  hu_audio_dma_rd_unpack_if.master bus
);
  state_t        state, state_nx;
  logic [31:0]   next_index, beats_left, smp_left, burst_cnt, burst_r, req_len;
  logic          odd_r;
  logic [32:0]   beats_sum;
  logic          ctrl_hs, beat_hs, smp_hs, last_beat, drop_hi;
  dma_ctrl_msg_t msg;

  assign beats_sum = {1'b0, cfg_num_samples} + 33'd1;
  assign req_len   = (burst_r < beats_left) ? burst_r : beats_left;
  assign msg       = '{size: DMA_SIZE_64, length: req_len, index: next_index};

  assign bus.dma_read_ctrl_valid       = (state == REQ);
  assign bus.dma_read_ctrl_data_index  = msg.index;
  assign bus.dma_read_ctrl_data_length = msg.length;
  assign bus.dma_read_ctrl_data_size   = msg.size;
  assign bus.smp_last                  = bus.smp_valid & (smp_left == 32'd1);

  assign ctrl_hs   = bus.dma_read_ctrl_valid & bus.dma_read_ctrl_ready;
  assign beat_hs   = bus.dma_read_chnl_valid & bus.dma_read_chnl_ready;
  assign smp_hs    = bus.smp_valid & bus.smp_ready;
  assign last_beat = (burst_cnt == 32'd1);
  // Odd counts: the final beat's high half is never a real sample.
  assign drop_hi   = odd_r & last_beat & (beats_left == 32'd0);

  assign busy = (state == REQ) | (state == DATA) | (state == DRAIN);
  assign done = (state == DONE);

  hu_audio_beat_unpack #(.DMA_W(DMA_W), .SMP_W(SMP_W)) u_unpack (
    .clk        (clk),
    .rst        (rst),
    .en         (state == DATA),
    .drop_hi    (drop_hi),
    .beat_valid (bus.dma_read_chnl_valid),
    .beat_data  (bus.dma_read_chnl_data),
    .beat_ready (bus.dma_read_chnl_ready),
    .smp_valid  (bus.smp_valid),
    .smp_data   (bus.smp_data),
    .smp_ready  (bus.smp_ready)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start) state_nx = (cfg_num_samples == 32'd0) ? DONE : REQ;
      REQ:   if (ctrl_hs) state_nx = DATA;
      DATA:  if (beat_hs && last_beat) state_nx = (beats_left != 32'd0) ? REQ : DRAIN;
      DRAIN: if (smp_hs && smp_left == 32'd1) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      next_index <= '0;
      beats_left <= '0;
      smp_left   <= '0;
      burst_cnt  <= '0;
      burst_r    <= '0;
      odd_r      <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        next_index <= cfg_base_index;
        beats_left <= beats_sum[32:1];
        smp_left   <= cfg_num_samples;
        burst_r    <= (cfg_burst_beats == '0) ? 32'd1
                      : {{(32-BURST_W){1'b0}}, cfg_burst_beats};
        odd_r      <= cfg_num_samples[0];
      end else if (smp_hs) begin
        smp_left <= smp_left - 32'd1;
      end
      if (ctrl_hs) begin
        burst_cnt  <= req_len;
        next_index <= next_index + req_len;
        beats_left <= beats_left - req_len;
      end else if (beat_hs) begin
        burst_cnt  <= burst_cnt - 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_hu_audio_dma_rd_unpack.sv
// Directed bench: table of transfers against a DMA memory model and sample scoreboard.
module tb_hu_audio_dma_rd_unpack;
  import hu_audio_dma_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] cfg_base_index, cfg_num_samples;
  logic [15:0] cfg_burst_beats;
  logic        busy, done;

  hu_audio_dma_rd_unpack_if bus();

  hu_audio_dma_rd_unpack dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_base_index(cfg_base_index), .cfg_num_samples(cfg_num_samples),
    .cfg_burst_beats(cfg_burst_beats), .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          n;
    int          burst;
    logic [31:0] base;
    int          cdly;
    bit          rnd;
    int          reqs;
    int          len0;
    logic [31:0] idx1;
    int          len1;
  } vec_t;

  int total = 0, bad = 0;

  // transfer mode, written by the stimulus process
  int          m_n = 0, m_cdly = 0;
  logic [31:0] m_base = '0;
  bit          m_rnd = 1'b0;

  // logs written only by the responder
  logic [31:0] req_idx[$];
  logic [31:0] req_len[$];
  logic [31:0] beatq[$];
  int cyc = 0, rx_cnt = 0, sb_err = 0, done_cnt = 0;
  int start_cyc = 0, last_hs_cyc = 0, done_cyc = 0;
  int chnl_viol = 0, stab_viol = 0, stall_viol = 0, size_viol = 0;
  logic busy1 = 1'b0, busy_at_done = 1'b0;

  function automatic logic [31:0] pat(logic [31:0] w, bit hi);
    return {hi ? 16'hB0B0 : 16'hA0A0, w[15:0]};
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  // DMA memory model, sample sink and protocol monitors
  initial begin : resp
    bit          ctrl_hs, chnl_hs, wait_prev, stall_prev, start_prev;
    logic [31:0] hs_idx, hs_len, held_idx, held_len, stall_data, w, xd;
    int          wcnt, k;
    ctrl_hs = 0; chnl_hs = 0; wait_prev = 0; stall_prev = 0; start_prev = 0;
    hs_idx = 0; hs_len = 0; held_idx = 0; held_len = 0; stall_data = 0; wcnt = 0;
    bus.dma_read_ctrl_ready = 1'b0;
    bus.dma_read_chnl_valid = 1'b0;
    bus.dma_read_chnl_data  = '0;
    bus.smp_ready           = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst !== 1'b1) begin
        beatq.delete();
        ctrl_hs = 0; chnl_hs = 0; wait_prev = 0; stall_prev = 0; start_prev = 0; wcnt = 0;
        bus.dma_read_ctrl_ready = 1'b0;
        bus.dma_read_chnl_valid = 1'b0;
        bus.dma_read_chnl_data  = '0;
        bus.smp_ready           = 1'b0;
        continue;
      end
      // effects of the handshakes that completed on the last rising edge
      if (ctrl_hs) begin
        req_idx.push_back(hs_idx);
        req_len.push_back(hs_len);
        for (int i = 0; i < int'(hs_len); i++) beatq.push_back(hs_idx + i);
        wcnt = 0;
      end
      if (chnl_hs && beatq.size() > 0) xd = beatq.pop_front();
      // drive this cycle
      bus.dma_read_chnl_valid = (beatq.size() > 0) && (!m_rnd || $urandom_range(0, 3) != 0);
      bus.dma_read_chnl_data  = (beatq.size() > 0) ? {pat(beatq[0], 1'b1), pat(beatq[0], 1'b0)} : 64'd0;
      bus.dma_read_ctrl_ready = (wcnt >= m_cdly);
      if (bus.dma_read_ctrl_valid) wcnt++;
      bus.smp_ready = m_rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      #1;
      if (start_prev) begin busy1 = busy; start_prev = 0; end
      if (start && !busy) begin
        req_idx.delete(); req_len.delete();
        rx_cnt = 0; sb_err = 0; done_cnt = 0;
        chnl_viol = 0; stab_viol = 0; stall_viol = 0; size_viol = 0;
        start_cyc = cyc; start_prev = 1;
      end
      ctrl_hs = bus.dma_read_ctrl_valid & bus.dma_read_ctrl_ready;
      hs_idx  = bus.dma_read_ctrl_data_index;
      hs_len  = bus.dma_read_ctrl_data_length;
      if (bus.dma_read_ctrl_valid && bus.dma_read_ctrl_data_size != DMA_SIZE_64) size_viol++;
      if (wait_prev && (!bus.dma_read_ctrl_valid || hs_idx != held_idx || hs_len != held_len))
        stab_viol++;
      wait_prev = bus.dma_read_ctrl_valid & ~bus.dma_read_ctrl_ready;
      held_idx = hs_idx; held_len = hs_len;
      chnl_hs = bus.dma_read_chnl_valid & bus.dma_read_chnl_ready;
      if (bus.dma_read_chnl_ready && (beatq.size() == 0 || bus.dma_read_ctrl_valid)) chnl_viol++;
      if (stall_prev && (!bus.smp_valid || bus.smp_data != stall_data)) stall_viol++;
      stall_prev = bus.smp_valid & ~bus.smp_ready;
      stall_data = bus.smp_data;
      if (bus.smp_valid && bus.smp_ready) begin
        k = rx_cnt;
        w = m_base + (k >> 1);
        if (bus.smp_data != pat(w, k[0])) sb_err++;
        if (bus.smp_last != (k == m_n - 1)) sb_err++;
        rx_cnt++;
        last_hs_cyc = cyc;
      end
      if (done) begin done_cnt++; done_cyc = cyc; busy_at_done = busy; end
    end
  end

  task automatic chk_reset_outs(string tag);
    chk({tag, "_ctrl_valid"}, bus.dma_read_ctrl_valid, 0);
    chk({tag, "_ctrl_index"}, bus.dma_read_ctrl_data_index, 0);
    chk({tag, "_ctrl_length"}, bus.dma_read_ctrl_data_length, 0);
    chk({tag, "_ctrl_size"}, bus.dma_read_ctrl_data_size, 3);
    chk({tag, "_chnl_ready"}, bus.dma_read_chnl_ready, 0);
    chk({tag, "_smp_valid"}, bus.smp_valid, 0);
    chk({tag, "_smp_data"}, bus.smp_data, 0);
    chk({tag, "_smp_last"}, bus.smp_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic launch(vec_t v);
    m_n = v.n; m_base = v.base; m_cdly = v.cdly; m_rnd = v.rnd;
    @(negedge clk);
    cfg_num_samples = v.n;
    cfg_burst_beats = 16'(v.burst);
    cfg_base_index  = v.base;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_vec(string nm, vec_t v);
    launch(v);
    for (int i = 0; i < 4000 && done_cnt == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    #2;
    chk({nm, "_done_cnt"}, done_cnt, 1);
    chk({nm, "_num_reqs"}, req_idx.size(), v.reqs);
    if (req_idx.size() > 0) begin
      chk({nm, "_idx0"}, req_idx[0], v.base);
      chk({nm, "_len0"}, req_len[0], v.len0);
    end
    if (v.reqs > 1 && req_idx.size() > 1) begin
      chk({nm, "_idx1"}, req_idx[1], v.idx1);
      chk({nm, "_len1"}, req_len[1], v.len1);
    end
    chk({nm, "_rx_cnt"}, rx_cnt, v.n);
    chk({nm, "_sb_err"}, sb_err, 0);
    chk({nm, "_done_lat"}, done_cyc - ((v.n == 0) ? start_cyc : last_hs_cyc), 1);
    chk({nm, "_busy_start"}, busy1, (v.n != 0));
    chk({nm, "_busy_at_done"}, busy_at_done, 0);
    chk({nm, "_busy_after"}, busy, 0);
    chk({nm, "_chnl_outside"}, chnl_viol, 0);
    chk({nm, "_req_stable"}, stab_viol, 0);
    chk({nm, "_smp_stall"}, stall_viol, 0);
    chk({nm, "_size"}, size_viol, 0);
  endtask

  vec_t vecs[7];
  vec_t v2;

  initial begin
    //            n   burst base           cdly rnd reqs len0 idx1          len1
    vecs[0] = '{  8,  4,   32'h0000_0100,  0,   0,  1,   4,   32'h0,        0};
    vecs[1] = '{  7,  2,   32'h0000_0100,  0,   0,  2,   2,   32'h0000_0102,2};
    vecs[2] = '{  0,  4,   32'h0000_0100,  0,   0,  0,   0,   32'h0,        0};
    vecs[3] = '{ 64,  8,   32'h0000_0200,  5,   1,  4,   8,   32'h0000_0208,8};
    vecs[4] = '{  4,  0,   32'h0000_0040,  0,   0,  2,   1,   32'h0000_0041,1};
    vecs[5] = '{  5,  2,   32'hFFFF_FFFF,  0,   0,  2,   2,   32'h0000_0001,1};
    vecs[6] = '{  1,  1,   32'h0000_0010,  0,   0,  1,   1,   32'h0,        0};
    v2      = '{  2,  4,   32'h0000_0300,  0,   0,  1,   1,   32'h0,        0};

    rst = 1'b1; start = 1'b0;
    cfg_base_index = '0; cfg_num_samples = '0; cfg_burst_beats = '0;
    #1 rst = 1'b0;
    #2 chk_reset_outs("por");
    repeat (3) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 7; i++) run_vec($sformatf("v%0d", i), vecs[i]);

    // abort mid-DATA, then a fresh short transfer
    launch('{64, 8, 32'h0000_0500, 0, 0, 0, 0, 32'h0, 0});
    for (int i = 0; i < 500 && rx_cnt < 5; i++) @(negedge clk);
    chk("abort_reached_data", rx_cnt >= 5, 1);
    @(negedge clk);
    rst = 1'b0;
    #2 chk_reset_outs("abort");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_no_req", bus.dma_read_ctrl_valid, 0);
    run_vec("post_rst", v2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
